// File: rtl/sar_search.sv
// Successive-approximation controller: recovers an unknown X, MSB first, by
// driving trial values into an external X > trial comparator.
module sar_search #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             gt_in,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [KW-1:0] K_TOP   = KW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] r;
  logic [KW-1:0]    k;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_next;

  // All ones strictly below bit idx.
  function automatic logic [WIDTH-1:0] below_mask(input logic [KW-1:0] idx);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) m[i] = (KW'(i) < idx);
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] bit_mask(input logic [KW-1:0] idx);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) m[i] = (KW'(i) == idx);
    return m;
  endfunction

  // Trial keeps the decided upper bits, clears bit k and fills below it with
  // ones, so X > trial exactly when X >= R + 2^k.
  always_comb begin
    r_next = gt_in ? (r | bit_mask(k)) : r;
    trial  = (state == S_SEARCH) ? (r | below_mask(k)) : '0;
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      r      <= '0;
      k      <= K_TOP;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            r     <= '0;
            k     <= K_TOP;
            cnt   <= '0;
            state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          // gt_in only matters on the last settle cycle of each bit.
          if (cnt == CNT_TOP) begin
            r <= r_next;
            if (k == '0) begin
              result <= r_next;
              state  <= S_DONE;
            end else begin
              k   <= k - 1'b1;
              cnt <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: comparator modelled from a bench-held X,
// trial/done/result checked cycle by cycle against hand-derived sequences.
module tb_sar_search;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, start_s = 1'b0, start_1 = 1'b0;
  logic [3:0] x = 4'd0;
  logic       gt_s = 1'b0;
  logic       x_1 = 1'b0;
  logic       gt, gt_1;
  logic [3:0] trial, result, trial_s, result_s;
  logic       busy, done, busy_s, done_s;
  logic       trial_1, result_1, busy_1, done_1;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  assign gt   = (x > trial);
  assign gt_1 = (x_1 > trial_1);

  sar_search #(.WIDTH(4), .SETTLE(0)) dut (
    .clk(clk), .reset(reset), .start(start), .gt_in(gt),
    .trial(trial), .busy(busy), .done(done), .result(result));

  sar_search #(.WIDTH(4), .SETTLE(2)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .gt_in(gt_s),
    .trial(trial_s), .busy(busy_s), .done(done_s), .result(result_s));

  sar_search #(.WIDTH(1), .SETTLE(0)) dut_1 (
    .clk(clk), .reset(reset), .start(start_1), .gt_in(gt_1),
    .trial(trial_1), .busy(busy_1), .done(done_1), .result(result_1));

  task automatic test_reset;
    @(posedge clk); #1;
    checks++;
    if ({trial, busy, done, result} !== 10'b0) begin
      failures++;
      $display("FAIL reset_state: trial=%0d busy=%b done=%b result=%0d, required all 0",
               trial, busy, done, result);
    end
    checks++;
    if ({trial_s, busy_s, done_s, result_s, trial_1, busy_1, done_1, result_1} !== 14'b0) begin
      failures++;
      $display("FAIL reset_state_aux: busy_s=%b busy_1=%b result_s=%0d, required all 0",
               busy_s, busy_1, result_s);
    end
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (trial !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || result !== 4'd0) begin
        failures++;
        $display("FAIL idle_hold c%0d: trial=%0d busy=%b done=%b result=%0d, required all 0",
                 c, trial, busy, done, result);
      end
    end
  endtask

  task automatic test_basic;
    logic [3:0] exp_t [4] = '{4'd7, 4'd11, 4'd9, 4'd10};
    x = 4'd11;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (trial !== exp_t[c-1] || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL basic_trial c%0d: trial=%0d busy=%b done=%b, required trial=%0d busy=1 done=0",
                 c, trial, busy, done, exp_t[c-1]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || result !== 4'd11 || trial !== 4'd0) begin
      failures++;
      $display("FAIL basic_done: done=%b busy=%b result=%0d trial=%0d, required 1 1 11 0",
               done, busy, result, trial);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 4'd11) begin
      failures++;
      $display("FAIL basic_after: done=%b busy=%b result=%0d, required 0 0 11",
               done, busy, result);
    end
  endtask

  task automatic test_extremes;
    logic [3:0] xs [2] = '{4'd0, 4'd15};
    logic [3:0] tt [2][4] = '{'{4'd7, 4'd3, 4'd1, 4'd0}, '{4'd7, 4'd11, 4'd13, 4'd14}};
    for (int v = 0; v < 2; v++) begin
      x = xs[v];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        checks++;
        if (trial !== tt[v][c-1]) begin
          failures++;
          $display("FAIL extreme_trial x=%0d c%0d: trial=%0d, required %0d",
                   xs[v], c, trial, tt[v][c-1]);
        end
        @(posedge clk); #1;
      end
      checks++;
      if (done !== 1'b1 || result !== xs[v]) begin
        failures++;
        $display("FAIL extreme_result x=%0d: done=%b result=%0d, required done=1 result=%0d",
                 xs[v], done, result, xs[v]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_settle;
    logic [3:0] exp_t [4] = '{4'd7, 4'd3, 4'd5, 4'd6};
    logic [3:0] xv = 4'd6;
    int b, ph;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      b  = (c - 1) / 3;
      ph = (c - 1) % 3;
      checks++;
      if (trial_s !== exp_t[b] || busy_s !== 1'b1 || done_s !== 1'b0) begin
        failures++;
        $display("FAIL settle_trial c%0d: trial=%0d busy=%b done=%b, required trial=%0d busy=1 done=0",
                 c, trial_s, busy_s, done_s, exp_t[b]);
      end
      gt_s = (ph == 2) ? (xv > trial_s) : !(xv > trial_s);
      @(posedge clk); #1;
    end
    checks++;
    if (done_s !== 1'b1 || result_s !== 4'd6) begin
      failures++;
      $display("FAIL settle_done: done=%b result=%0d, required done=1 result=6", done_s, result_s);
    end
    @(posedge clk); #1;
    checks++;
    if (done_s !== 1'b0 || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL settle_after: done=%b busy=%b, required 0 0", done_s, busy_s);
    end
  endtask

  task automatic test_width1;
    logic xs [2] = '{1'b1, 1'b0};
    for (int v = 0; v < 2; v++) begin
      x_1 = xs[v];
      start_1 = 1'b1;
      @(posedge clk); #1;
      start_1 = 1'b0;
      checks++;
      if (trial_1 !== 1'b0 || busy_1 !== 1'b1 || done_1 !== 1'b0) begin
        failures++;
        $display("FAIL w1_search x=%0d: trial=%b busy=%b done=%b, required 0 1 0",
                 xs[v], trial_1, busy_1, done_1);
      end
      @(posedge clk); #1;
      checks++;
      if (done_1 !== 1'b1 || result_1 !== xs[v]) begin
        failures++;
        $display("FAIL w1_result x=%0d: done=%b result=%b, required done=1 result=%b",
                 xs[v], done_1, result_1, xs[v]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_t [4] = '{4'd7, 4'd11, 4'd9, 4'd8};
    int ph;
    x = 4'd9;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 17; c++) begin
      ph = c % 6;
      checks++;
      if (done !== (ph == 5) || busy !== (ph != 0)) begin
        failures++;
        $display("FAIL b2b_ctrl c%0d: done=%b busy=%b, required done=%b busy=%b",
                 c, done, busy, (ph == 5), (ph != 0));
      end
      if (ph == 5) begin
        checks++;
        if (result !== 4'd9) begin
          failures++;
          $display("FAIL b2b_result c%0d: result=%0d, required 9", c, result);
        end
      end
      if (ph >= 1 && ph <= 4) begin
        checks++;
        if (trial !== exp_t[ph-1]) begin
          failures++;
          $display("FAIL b2b_trial c%0d: trial=%0d, required %0d", c, trial, exp_t[ph-1]);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || result !== 4'd9) begin
      failures++;
      $display("FAIL b2b_stop: busy=%b result=%0d, required busy=0 result=9", busy, result);
    end
  endtask

  task automatic test_reset_mid_search;
    logic [3:0] pre_t [3] = '{4'd7, 4'd11, 4'd13};
    logic [3:0] exp_t [4] = '{4'd7, 4'd3, 4'd5, 4'd4};
    x = 4'd13;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (trial !== pre_t[c-1]) begin
        failures++;
        $display("FAIL mid_trial c%0d: trial=%0d, required %0d", c, trial, pre_t[c-1]);
      end
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (trial !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || result !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset: trial=%0d busy=%b done=%b result=%0d, required all 0",
               trial, busy, done, result);
    end
    #2 reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || trial !== 4'd0) begin
      failures++;
      $display("FAIL mid_idle: busy=%b trial=%0d, required 0 0", busy, trial);
    end
    x = 4'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (trial !== exp_t[c-1]) begin
        failures++;
        $display("FAIL mid_new_trial c%0d: trial=%0d, required %0d", c, trial, exp_t[c-1]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done !== 1'b1 || result !== 4'd5) begin
      failures++;
      $display("FAIL mid_new_result: done=%b result=%0d, required done=1 result=5", done, result);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_settle();
    test_width1();
    test_back_to_back();
    test_reset_mid_search();
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
